// File: rtl/johnson_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : johnson_seq_pkg
// Description : Shared types and constants for the Johnson-counter sequencer.
//               Holds the controller state encoding and the direction codes
//               used on cmd_dir and inside the counter core.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package johnson_seq_pkg;

    // Controller states; encoding is fixed so it can be probed externally.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Direction codes carried on cmd_dir and the core dir input.
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage : johnson_seq_pkg
`default_nettype wire

// File: rtl/johnson_core.sv
`default_nettype none
// ============================================================================
// Module      : johnson_core
// Description : N-bit Johnson counter register with enable and direction,
//               plus a combinational decode of the counter state into its
//               index within the forward sequence (0 .. 2N-1).
// Ports       : clk    - clock, rising edge
//               reset  - synchronous reset, active low
//               en     - advance the counter by one state this edge
//               dir    - 0 = forward, 1 = reverse
//               count  - registered Johnson state
//               phase  - forward-sequence index of count
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_core
    import johnson_seq_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          dir,
    output logic [N-1:0]  count,
    output logic [PW-1:0] phase
);

    // 2N truncated to PW bits. When 2N is a power of two this is 0, and the
    // modular subtraction below still yields 2N - p.
    localparam logic [PW-1:0] C_TWO_N = PW'(2 * N);

    logic [N-1:0]  count_q;
    logic [N-1:0]  count_d;
    logic [PW-1:0] w_popcnt;

    // Forward feeds the inverted MSB into the LSB; reverse is its exact
    // inverse, feeding the inverted LSB into the MSB.
    always_comb begin
        count_d = count_q;
        if (en) begin
            if (dir == DIR_REV) begin
                count_d = {~count_q[0], count_q[N-1:1]};
            end else begin
                count_d = {count_q[N-2:0], ~count_q[N-1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The first N forward states fill with ones from the LSB (index = number
    // of ones); the second N drain ones from the LSB end, so bit 0 is clear
    // and the index counts back down from 2N.
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < N; i++) begin
            w_popcnt = w_popcnt + {{(PW-1){1'b0}}, count_q[i]};
        end
        if (count_q[0] || (count_q == '0)) begin
            phase = w_popcnt;
        end else begin
            phase = C_TWO_N - w_popcnt;
        end
    end

    assign count = count_q;

endmodule : johnson_core
`default_nettype wire

// File: rtl/johnson_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : johnson_sequencer
// Description : Command-driven controller that advances a Johnson counter a
//               requested number of steps in a chosen direction, with pause
//               and abort, a one-cycle done pulse and a decoded phase index.
// Ports       : clk        - clock, rising edge
//               reset      - synchronous reset, active low
//               cmd_valid  - command present
//               cmd_ready  - high in IDLE; accept = valid & ready at an edge
//               cmd_steps  - number of advances requested
//               cmd_dir    - 0 = forward, 1 = reverse
//               pause      - hold counter and step count while running
//               abort      - end the run without a done pulse
//               count      - Johnson counter state
//               phase      - forward-sequence index of count
//               steps_left - remaining advances
//               busy       - high while running
//               done       - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_sequencer
    import johnson_seq_pkg::*;
#(
    parameter int N      = 4,
    parameter int STEP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [STEP_W-1:0]        cmd_steps,
    input  logic                     cmd_dir,
    input  logic                     pause,
    input  logic                     abort,
    output logic [N-1:0]             count,
    output logic [$clog2(2*N)-1:0]   phase,
    output logic [STEP_W-1:0]        steps_left,
    output logic                     busy,
    output logic                     done
);

    localparam logic [STEP_W-1:0] C_ONE = STEP_W'(1);

    state_t              state_q;
    state_t              state_d;
    logic [STEP_W-1:0]   steps_left_q;
    logic [STEP_W-1:0]   steps_left_d;
    logic                dir_q;
    logic                dir_d;
    logic                busy_q;
    logic                done_q;
    logic                ready_q;
    logic                w_core_en;

    // The counter moves exactly when the run advances; abort outranks pause
    // but both stop the shift on their edge.
    assign w_core_en = (state_q == RUN) & ~pause & ~abort;

    johnson_core #(
        .N (N)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (w_core_en),
        .dir   (dir_q),
        .count (count),
        .phase (phase)
    );

    always_comb begin
        state_d      = state_q;
        steps_left_d = steps_left_q;
        dir_d        = dir_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // A zero-step command completes immediately; loading the
                    // field anyway keeps steps_left at 0 for the done cycle.
                    steps_left_d = cmd_steps;
                    if (cmd_steps == '0) begin
                        state_d = DONE;
                    end else begin
                        dir_d   = cmd_dir;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    steps_left_d = steps_left_q - C_ONE;
                    if (steps_left_q == C_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next-state so they line up with
    // the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            steps_left_q <= '0;
            dir_q        <= DIR_FWD;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            steps_left_q <= steps_left_d;
            dir_q        <= dir_d;
            busy_q       <= (state_d == RUN);
            done_q       <= (state_d == DONE);
            ready_q      <= (state_d == IDLE);
        end
    end

    assign cmd_ready  = ready_q;
    assign steps_left = steps_left_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule : johnson_sequencer
`default_nettype wire

// File: tb/tb_johnson_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_johnson_sequencer
// Description : Self-checking bench for johnson_sequencer (N=4, STEP_W=8).
//               A table of back-to-back commands plus hand-written sequences
//               for pause, abort, zero-step and reset-during-run. Each
//               accepted command pushes its expected completion onto a
//               scoreboard that a done-monitor pops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_steps;
    logic       cmd_dir;
    logic       pause;
    logic       abort;
    logic [3:0] count;
    logic [2:0] phase;
    logic [7:0] steps_left;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         exp_cyc;
        logic [3:0] exp_count;
        logic [2:0] exp_phase;
        bit         chk_sl;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [7:0] steps;
        logic       dir;
        logic [3:0] exp_count;
        logic [2:0] exp_phase;
    } vec_t;
    vec_t vecs[8];

    logic [3:0] fwd_seq[8];

    johnson_sequencer #(
        .N      (4),
        .STEP_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .pause      (pause),
        .abort      (abort),
        .count      (count),
        .phase      (phase),
        .steps_left (steps_left),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Done monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("done_cycle", cyc, e.exp_cyc);
                chk("done_count", {28'd0, count}, {28'd0, e.exp_count});
                chk("done_phase", {29'd0, phase}, {29'd0, e.exp_phase});
                chk("done_busy", {31'd0, busy}, 32'd0);
                if (e.chk_sl) chk("done_steps_left", {24'd0, steps_left}, 32'd0);
            end
        end
    end

    task automatic send_cmd(input logic [7:0] s, input logic d, output int k);
        bit acc;
        bit rdy;
        int n;
        acc = 0;
        n   = 0;
        cmd_valid = 1'b1;
        cmd_steps = s;
        cmd_dir   = d;
        while (!acc && n < 50) begin
            rdy = cmd_ready;
            tick();
            n++;
            if (rdy) acc = 1;
        end
        k = cyc;
        cmd_valid = 1'b0;
        chk("cmd_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic expect_done(input int kd, input logic [3:0] c, input logic [2:0] p, input bit sl);
        sb_t e;
        e.exp_cyc   = kd;
        e.exp_count = c;
        e.exp_phase = p;
        e.chk_sl    = sl;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        chk("drain_timeout", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int idx;

        fwd_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        // Back-to-back commands starting from 1110 (index 5).
        vecs[0] = '{8'd3,   1'b1, 4'b0011, 3'd2};
        vecs[1] = '{8'd10,  1'b0, 4'b1111, 3'd4};
        vecs[2] = '{8'd0,   1'b1, 4'b1111, 3'd4};
        vecs[3] = '{8'd255, 1'b1, 4'b1110, 3'd5};
        vecs[4] = '{8'd8,   1'b0, 4'b1110, 3'd5};
        vecs[5] = '{8'd1,   1'b0, 4'b1100, 3'd6};
        vecs[6] = '{8'd1,   1'b1, 4'b1110, 3'd5};
        vecs[7] = '{8'd3,   1'b0, 4'b0000, 3'd0};

        reset = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0;
        pause = 1'b0; abort = 1'b0;

        // Reset
        tick();
        tick();
        reset = 1'b1;
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_phase", {29'd0, phase}, 32'd0);
        chk("rst_steps_left", {24'd0, steps_left}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Forward 5 from 0000, checked every edge
        send_cmd(8'd5, 1'b0, k);
        expect_done(k + 5, 4'b1110, 3'd5, 1'b1);
        chk("f5_busy", {31'd0, busy}, 32'd1);
        chk("f5_sl0", {24'd0, steps_left}, 32'd5);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("f5_count", {28'd0, count}, {28'd0, fwd_seq[i]});
            chk("f5_phase", {29'd0, phase}, i);
            chk("f5_sl", {24'd0, steps_left}, 5 - i);
        end
        drain();
        tick();
        tick();
        chk("f5_hold", {28'd0, count}, {28'd0, 4'b1110});
        chk("f5_ready", {31'd0, cmd_ready}, 32'd1);

        // Table of commands
        for (int v = 0; v < 8; v++) begin
            send_cmd(vecs[v].steps, vecs[v].dir, k);
            expect_done(k + int'(vecs[v].steps), vecs[v].exp_count, vecs[v].exp_phase,
                        vecs[v].steps != 0);
            drain();
        end

        // Pause: forward 4 from 0000, pause for 3 edges after the second shift
        send_cmd(8'd4, 1'b0, k);
        expect_done(k + 4 + 3, 4'b1111, 3'd4, 1'b1);
        tick();
        tick();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause_count", {28'd0, count}, {28'd0, 4'b0011});
            chk("pause_sl", {24'd0, steps_left}, 32'd2);
            chk("pause_busy", {31'd0, busy}, 32'd1);
        end
        pause = 1'b0;
        drain();

        // Return to 0000, then abort a 20-step run after 6 shifts
        send_cmd(8'd4, 1'b1, k);
        expect_done(k + 4, 4'b0000, 3'd0, 1'b1);
        drain();
        send_cmd(8'd20, 1'b0, k);
        for (int i = 0; i < 6; i++) tick();
        chk("abort_pre_count", {28'd0, count}, {28'd0, 4'b1100});
        abort = 1'b1;
        pause = 1'b1;
        tick();
        abort = 1'b0;
        pause = 1'b0;
        chk("abort_count", {28'd0, count}, {28'd0, 4'b1100});
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_sl", {24'd0, steps_left}, 32'd14);
        tick();
        tick();
        chk("abort_no_shift", {28'd0, count}, {28'd0, 4'b1100});

        // Zero-step command: done right after accept, count unchanged
        send_cmd(8'd0, 1'b0, k);
        expect_done(k, 4'b1100, 3'd6, 1'b1);
        drain();

        // Reset during RUN while a new command is held valid
        send_cmd(8'd10, 1'b0, k);
        cmd_valid = 1'b1;
        cmd_steps = 8'd3;
        cmd_dir   = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            idx = (6 + i) % 8;
            chk("rr_count", {28'd0, count}, {28'd0, fwd_seq[idx]});
            chk("rr_phase", {29'd0, phase}, idx);
        end
        chk("rr_not_accepted", {24'd0, steps_left}, 32'd7);
        chk("rr_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rr_count0", {28'd0, count}, 32'd0);
        chk("rr_idle", {31'd0, cmd_ready}, 32'd1);
        chk("rr_busy0", {31'd0, busy}, 32'd0);
        chk("rr_sl0", {24'd0, steps_left}, 32'd0);
        tick();
        k = cyc;
        cmd_valid = 1'b0;
        expect_done(k + 3, 4'b0111, 3'd3, 1'b1);
        chk("rr_accepted_busy", {31'd0, busy}, 32'd1);
        chk("rr_accepted_sl", {24'd0, steps_left}, 32'd3);
        drain();
        tick();
        tick();

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_johnson_sequencer
`default_nettype wire
